// File: rtl/xor_rr_arbiter.sv
// rtl/xor_rr_arbiter.sv - two-requester round-robin front end for a shared XOR unit
module xor_rr_arbiter #(
    parameter int LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic req0_valid,
    input  logic req1_valid,
    input  logic req0_a,
    input  logic req0_b,
    input  logic req1_a,
    input  logic req1_b,
    output logic req0_ready,
    output logic req1_ready,
    output logic xor_a,
    output logic xor_b,
    input  logic xor_y,
    output logic rsp_valid,
    output logic rsp_id,
    output logic rsp_y,
    input  logic rsp_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] LAT_CNT = 2'(LATENCY);

    state_t     state;
    logic [1:0] wait_cnt;
    logic       last_grant;
    logic       grant_id;
    logic       accept;
    logic       acc_a;
    logic       acc_b;

    // On a tie the requester not served last wins; last_grant resets to 1 so req0 wins first.
    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
    end

    // Gated by rst so no ready leaks out while the block is held in reset.
    assign req0_ready = rst && (state == IDLE) && req0_valid && !grant_id;
    assign req1_ready = rst && (state == IDLE) && req1_valid && grant_id;
    assign accept     = req0_ready || req1_ready;
    assign acc_a      = grant_id ? req1_a : req0_a;
    assign acc_b      = grant_id ? req1_b : req0_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            wait_cnt   <= 2'd0;
            last_grant <= 1'b1;
            xor_a      <= 1'b0;
            xor_b      <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_y      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        xor_a    <= acc_a;
                        xor_b    <= acc_b;
                        rsp_id   <= grant_id;
                        wait_cnt <= LAT_CNT;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        rsp_y     <= xor_y;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        last_grant <= rsp_id;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/xor_rr_arbiter.md
XOR_RR_ARBITER -- requirements
Module: xor_rr_arbiter

Interface
REQ-001 The block SHALL have parameter LATENCY, default 1: cycles from stable shared-XOR inputs to valid xor_y; legal range 0..3.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have ports req0_valid, req1_valid  input  1  requester N has an operand pair.
REQ-005 The block SHALL have ports req0_a, req0_b, req1_a, req1_b  input  1  requester operands.
REQ-006 The block SHALL have ports req0_ready, req1_ready  output  1  operand pair accepted this cycle.
REQ-007 The block SHALL have ports xor_a, xor_b  output  1  operands driven to the shared XOR unit.
REQ-008 The block SHALL have port xor_y  input  1  shared XOR unit result.
REQ-009 The block SHALL have ports rsp_valid  output  1, rsp_id  output  1, and rsp_y  output  1: response present, owning requester, and result.
REQ-010 The block SHALL have port rsp_ready  input  1  consumer accepts response.

Function
REQ-011 The FSM SHALL have states IDLE, WAIT, and RESP, with one transaction in flight at most.
REQ-012 In IDLE, the block SHALL grant as follows: only one valid -> that requester; both valid -> the requester not granted last; none -> stay IDLE.
REQ-013 reqN_ready SHALL be 1 only in IDLE and only for the granted requester (combinational from state, valids, and last-grant).
REQ-014 On acceptance in cycle T (valid & ready), the block SHALL register operands into xor_a/xor_b, record rsp_id, load the wait counter with LATENCY, and enter WAIT.
REQ-015 In WAIT, the counter SHALL decrement each cycle; at count 0 the block SHALL capture xor_y into rsp_y and enter RESP; capture occurs at end of cycle T+1+LATENCY.
REQ-016 In RESP, rsp_valid SHALL be 1 from cycle T+2+LATENCY, and rsp_y/rsp_id SHALL be held stable until rsp_ready=1.
REQ-017 On rsp_valid & rsp_ready, the block SHALL update last-grant to rsp_id and return to IDLE; a new grant is possible in the next cycle, giving a minimum initiation interval of LATENCY+3 cycles.
REQ-018 xor_a/xor_b SHALL hold the last accepted operands in all states and SHALL not change outside acceptance.
REQ-019 A requester dropping valid while not granted SHALL have no effect; valid is not required to be held.
REQ-020 rsp_ready asserted outside RESP SHALL be ignored.
REQ-021 Fairness: with both requesters continuously valid, grants SHALL strictly alternate.

Reset
REQ-022 While rst=0, the block SHALL force state=IDLE, counter=0, last-grant=1 (req0 wins the first tie), xor_a=xor_b=0, rsp_valid=0, rsp_id=0, rsp_y=0, and req0_ready=req1_ready=0.
REQ-023 Reset asserted mid-transaction (WAIT or RESP) SHALL discard that transaction with no response produced; after release the block SHALL start in IDLE.
REQ-024 After rst rises, the first acceptance SHALL be possible in the first clock cycle.

Verification
REQ-025 Reset: hold rst=0 for 2 cycles with both valids high -> all outputs 0 and no ready asserted; after release, req0 is granted first.
REQ-026 Single request, LATENCY=1: req0 with a=1, b=0 accepted at T -> xor_a=1, xor_b=0 from T+1; rsp_valid=1, rsp_id=0, rsp_y=1 at T+3.
REQ-027 Contention: both valid continuously with operands (1,1) and (0,1), rsp_ready=1 -> grants alternate 0,1,0,1 and responses are (id0,y0),(id1,y1) alternately, each LATENCY+3 cycles apart.
REQ-028 Backpressure: hold rsp_ready=0 for 4 cycles in RESP -> rsp_valid, rsp_id, and rsp_y stay stable, no new ready is asserted, and return to IDLE occurs the cycle after rsp_ready=1.
REQ-029 Mid-op reset: assert rst=0 during WAIT -> no rsp_valid is ever produced for that request, and the next request completes normally.
REQ-030 Latency sweep: LATENCY=0 and 3 with all four operand combinations -> rsp_y equals a XOR b, rsp_valid appears at T+2+LATENCY.
